// File: rtl/mips_pkg.sv
// Shared constants for the instruction-fetch front end: instruction size,
// default datapath widths and the default boot address.
package mips_pkg;

    localparam int          INSTR_BYTES  = 4;
    localparam int          DEF_ADDR_W   = 32;
    localparam int          DEF_DATA_W   = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_queue.sv
// Circular fetch queue holding {pc, instr} entries. Flush empties it in one
// cycle; a push and a pop in the same cycle are allowed even when full.
module if_fetch_queue #(
    parameter int  DEPTH = 4,
    parameter int  WIDTH = 64,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign empty  = (r_count == '0);
    assign full   = (r_count == CNT_W'(DEPTH));
    assign count  = r_count;
    assign rdata  = r_mem[r_rd_ptr];
    assign w_pop  = pop && !empty;
    // A push into a full queue is only legal when the head leaves in the same cycle.
    assign w_push = push && (!full || w_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: issues sequential reads to a 1-cycle instruction memory,
// queues {pc, instr} for decode, and redirects on taken branches.
module if_fetch_unit
    import mips_pkg::*;
#(
    parameter int               ADDR_W   = DEF_ADDR_W,
    parameter int               DATA_W   = DEF_DATA_W,
    parameter int               DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [ADDR_W-1:0] br_offset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_instr
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;
    localparam int ENT_W = ADDR_W + DATA_W;

    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_req_addr;
    logic              r_inflight;

    logic [CNT_W-1:0]  w_count;
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic [OCC_W-1:0]  w_occ;
    logic [ADDR_W-1:0] w_target;
    logic [ENT_W-1:0]  w_head;

    assign imem_addr = r_fetch_pc;
    assign out_valid = !w_empty;
    assign out_pc    = out_valid ? w_head[ENT_W-1:DATA_W] : '0;
    assign out_instr = out_valid ? w_head[DATA_W-1:0]     : '0;
    assign w_pop     = out_valid && out_ready;

    // Slots already promised: held entries plus the response still on its way.
    assign w_occ    = OCC_W'(w_count) + OCC_W'(r_inflight) - OCC_W'(w_pop);
    assign imem_req = !rst && !br_taken && (w_occ < OCC_W'(DEPTH));
    assign w_target = br_pc + ADDR_W'(INSTR_BYTES) + (br_offset << 2);

    // A redirect in the response cycle kills the request issued one cycle earlier.
    assign w_push = r_inflight && !br_taken && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_req_addr <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= imem_req;
            if (imem_req) begin
                r_req_addr <= r_fetch_pc;
            end
            if (br_taken) begin
                r_fetch_pc <= w_target;
            end else if (imem_req) begin
                r_fetch_pc <= r_fetch_pc + ADDR_W'(INSTR_BYTES);
            end
        end
    end

    if_fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .flush (br_taken),
        .wdata ({r_req_addr, imem_rdata}),
        .rdata (w_head),
        .count (w_count),
        .empty (w_empty),
        .full  (w_full)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: streaming, back-pressure, redirects,
// mid-stream reset, and PC wrap on a second instance booting near 2^32.
module tb_if_fetch_unit;

    localparam logic [31:0] KEY = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, br_taken, out_ready;
    logic [31:0] br_pc, br_offset;
    logic        imem_req, out_valid;
    logic [31:0] imem_addr, imem_rdata, out_pc, out_instr;

    logic        rst_b, imem_req_b, out_valid_b;
    logic [31:0] imem_addr_b, imem_rdata_b, out_pc_b, out_instr_b;
    logic        zero_b = 1'b0;
    logic        one_b  = 1'b1;
    logic [31:0] zero32 = 32'h0;

    int          n_checks = 0;
    int          n_errors = 0;
    int          req_cnt;
    logic [31:0] exp_q[$];
    logic [31:0] e;

    if_fetch_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h0)) u_dut (
        .clk(clk), .rst(rst), .br_taken(br_taken), .br_pc(br_pc), .br_offset(br_offset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr)
    );

    if_fetch_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
        .clk(clk), .rst(rst_b), .br_taken(zero_b), .br_pc(zero32), .br_offset(zero32),
        .imem_req(imem_req_b), .imem_addr(imem_addr_b), .imem_rdata(imem_rdata_b),
        .out_valid(out_valid_b), .out_ready(one_b), .out_pc(out_pc_b), .out_instr(out_instr_b)
    );

    // One-cycle instruction memory whose contents are address ^ KEY.
    always @(posedge clk) begin
        imem_rdata   <= imem_addr ^ KEY;
        imem_rdata_b <= imem_addr_b ^ KEY;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        rst = 1'b1; rst_b = 1'b1; br_taken = 1'b0; out_ready = 1'b1;
        br_pc = '0; br_offset = '0;
        tick(); tick(); #1;
        chk("rst_req", imem_req, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_instr", out_instr, 0);
        chk("rst_b_req", imem_req_b, 0);

        // Streaming from reset release.
        rst = 1'b0; #1;
        chk("s_first_req", imem_req, 1);
        chk("s_first_addr", imem_addr, 0);
        tick(); #1;
        chk("s_c1_valid", out_valid, 0);
        for (int k = 0; k < 4; k++) begin
            tick(); #1;
            chk("s_valid", out_valid, 1);
            chk("s_pc", out_pc, 32'(4 * k));
            chk("s_instr", out_instr, 32'(4 * k) ^ KEY);
        end

        // Back-pressure for 10 cycles from a fresh reset.
        rst = 1'b1; tick();
        rst = 1'b0; out_ready = 1'b0; req_cnt = 0;
        for (int d = 0; d < 10; d++) begin
            if (d > 0) tick();
            #1;
            req_cnt += int'(imem_req);
            if (d == 3) begin
                chk("bp_d3_req", imem_req, 1);
                chk("bp_d3_addr", imem_addr, 32'd12);
            end
            if (d == 4) chk("bp_d4_req", imem_req, 0);
        end
        chk("bp_valid", out_valid, 1);
        chk("bp_pc", out_pc, 0);
        chk("bp_req_cnt", 64'(req_cnt), 4);
        for (int j = 0; j < 5; j++) exp_q.push_back(32'(4 * j));
        for (int j = 0; j < 5; j++) begin
            tick();
            if (j == 0) out_ready = 1'b1;
            #1;
            e = exp_q.pop_front();
            chk("rel_valid", out_valid, 1);
            chk("rel_pc", out_pc, e);
        end

        // Redirect: 0x100 + 4 + (0x10 << 2) = 0x144.
        tick(); br_taken = 1'b1; br_pc = 32'h100; br_offset = 32'h10; #1;
        chk("br_t_req", imem_req, 0);
        tick(); br_taken = 1'b0; #1;
        chk("br_t1_valid", out_valid, 0);
        chk("br_t1_req", imem_req, 1);
        chk("br_t1_addr", imem_addr, 32'h144);
        tick(); #1;
        chk("br_t2_valid", out_valid, 0);
        tick(); #1;
        chk("br_t3_valid", out_valid, 1);
        chk("br_t3_pc", out_pc, 32'h144);
        chk("br_t3_instr", out_instr, 32'h144 ^ KEY);
        tick(); #1;
        chk("br_t4_pc", out_pc, 32'h148);

        // Back-to-back redirects to 0x200 then 0x300; the second wins.
        tick(); br_taken = 1'b1; br_pc = 32'h1FC; br_offset = 32'h0; #1;
        chk("bb_u_req", imem_req, 0);
        tick(); br_pc = 32'h2FC; #1;
        chk("bb_u1_req", imem_req, 0);
        chk("bb_u1_valid", out_valid, 0);
        tick(); br_taken = 1'b0; #1;
        chk("bb_u2_valid", out_valid, 0);
        chk("bb_u2_addr", imem_addr, 32'h300);
        tick(); #1;
        chk("bb_u3_valid", out_valid, 0);
        tick(); #1;
        chk("bb_u4_pc", out_pc, 32'h300);
        tick(); #1;
        chk("bb_u5_pc", out_pc, 32'h304);

        // Negative offset: 0x100 + 4 - 8 = 0xFC.
        tick(); br_taken = 1'b1; br_pc = 32'h100; br_offset = 32'hFFFF_FFFE; #1;
        tick(); br_taken = 1'b0; #1;
        chk("neg_addr", imem_addr, 32'hFC);
        tick(); #1;
        tick(); #1;
        chk("neg_pc", out_pc, 32'hFC);

        // Reset mid-stream with the queue filling and a response in flight.
        tick(); out_ready = 1'b0; #1;
        tick(); #1;
        tick(); rst = 1'b1; #1;
        tick(); #1;
        chk("mr_valid", out_valid, 0);
        chk("mr_req", imem_req, 0);
        chk("mr_pc", out_pc, 0);
        chk("mr_instr", out_instr, 0);
        tick(); rst = 1'b0; out_ready = 1'b1; #1;
        chk("mr_rel_req", imem_req, 1);
        chk("mr_rel_addr", imem_addr, 0);
        chk("mr_rel_valid", out_valid, 0);
        tick(); #1;
        chk("mr_c1_valid", out_valid, 0);
        tick(); #1;
        chk("mr_c2_valid", out_valid, 1);
        chk("mr_c2_pc", out_pc, 0);

        // PC wrap on the second instance.
        tick(); rst_b = 1'b0; #1;
        chk("wr_req", imem_req_b, 1);
        chk("wr_addr", imem_addr_b, 32'hFFFF_FFF8);
        tick(); #1;
        exp_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
        for (int w = 0; w < 4; w++) begin
            tick(); #1;
            e = exp_q.pop_front();
            chk("wr_valid", out_valid_b, 1);
            chk("wr_pc", out_pc_b, e);
            chk("wr_instr", out_instr_b, e ^ KEY);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
